sha256_stream_core: RTL and testbench
=====================================

// Module: sha256_stream_core
// PURPOSE
//  Parametrised SHA-256 engine for the miner datapath: accepts caller-padded 512-bit blocks over ready/valid,
//  chains any number of blocks, optionally re-hashes the final digest (SHA256d), returns 256-bit digest on ready/valid.
//  Replaces the fixed 640-bit double-hash core; sits between header/nonce generator and target comparator.
// PARAMETERS
//  UNROLL  1  compression rounds per clock; legal 1,2,4 (divides 64); other values -> elaboration error
//  DOUBLE  1  1: digest of last block re-hashed as one padded 256-bit message; 0: plain SHA-256
// PORTS
//  clk         in   1    clock
//  rst_n       in   1    reset, asynchronous, active-low
//  abort       in   1    synchronous abandon of current message
//  blk_valid   in   1    block offered
//  blk_ready   out  1    core can accept block (=1 only in IDLE)
//  blk_data    in   512  padded block, word0 = [511:480], big-endian words
//  blk_first   in   1    block starts new message: chaining value <- IV (or midstate, see CONFIGURATION)
//  blk_last    in   1    block ends message
//  dig_valid   out  1    digest available
//  dig_ready   in   1    digest consumed
//  digest      out  256  H0 at [255:224] .. H7 at [31:0]
//  busy        out  1    state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, H0..H7 = IV, a..h = 0, W = 0, pass = 0, dig_valid = 0, digest = 0, busy = 0; blk_ready = 1 after release.
//  - IDLE: handshake on blk_valid&blk_ready -> W[0..15] <- blk_data; a..h <- (blk_first ? IV : H); H <- same; rnd <= 0; -> ROUND.
//  - ROUND: UNROLL rounds/clock, K and W schedule per FIPS 180-4, 16-word sliding window; rnd += UNROLL; at rnd == 64-UNROLL -> ADD.
//  - ADD (1 clk): Hn = H + {a..h} mod 2^32 per word.
//      !blk_last (latched at accept) -> H <= Hn, IDLE.
//      last & DOUBLE & pass==0 -> W <= {Hn, 32'h80000000, 6x32'h0, 32'h00000100}; H, a..h <= IV; pass <= 1; -> ROUND.
//      otherwise -> digest <= Hn, dig_valid <= 1, pass <= 0, -> OUT.
//  - OUT: hold digest/dig_valid until dig_ready; on dig_valid&dig_ready -> dig_valid 0, IDLE. blk_ready = 0 in OUT (no overlap).
//  - Latency, accept edge to dig_valid high: R = 64/UNROLL; single pass R+2 clocks; DOUBLE adds R+1.
//    UNROLL=1: 66 / 131. UNROLL=4: 18 / 35. Non-last block returns blk_ready after R+1 clocks.
//  - blk_first on any block restarts chaining (previous partial message discarded, no error).
//  - blk_first & blk_last: single-block message. blk_last without prior first: chains onto current H.
//  - abort: dominates all; next clock state IDLE, dig_valid 0, pass 0, H <= IV; digest register keeps old value.
//  - abort simultaneous with accept: block dropped. abort in OUT: digest discarded.
//  - rst_n low mid-operation: immediate return to reset values; no output glitch beyond async clear.
//  - Inputs sampled only at accept edge; blk_data may change afterwards.
// CONFIGURATION
//  SHA256_MIDSTATE_EN defined: extra ports  mid_in in 256 (H0 at [255:224])  mid_sel in 1.
//    At accept with blk_first & mid_sel: chaining value <- mid_in instead of IV (precomputed header midstate;
//    lets nonce sweep submit only 2nd header block). Second DOUBLE pass always uses IV.
//    mid_sel ignored when blk_first = 0.
//  Undefined: ports absent; blk_first always selects IV.
// TESTING
//  1 DOUBLE=0: "abc" block 61626380 00..00 00000018, first=last=1 -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad,
//    dig_valid at +66 (UNROLL=1), +18 (UNROLL=4).
//  2 DOUBLE=0: two-block "abcdbcde...nopq" (448 bits) first then last -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
//  3 DOUBLE=1: "abc" -> 4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358 at +131 (UNROLL=1).
//  4 DOUBLE=1: Bitcoin genesis header (80 B, 2 padded blocks, length 0x280)
//    -> 6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000; repeat with MIDSTATE_EN feeding block-1 midstate + block 2 only -> same.
//  5 dig_ready held 0 for 20 clks -> digest/dig_valid stable, blk_ready 0; release -> blk_ready 1 next clk.
//  6 abort at ROUND rnd=30, then "abc" first=last -> correct "abc" digest; rst_n pulsed mid-ROUND -> all outputs reset values.

Source files
------------

// File: rtl/sha256_stream_core_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_stream_core_if
// Purpose  : Block-in / digest-out handshake bundle for sha256_stream_core.
//            Midstate ports exist only when SHA256_MIDSTATE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface sha256_stream_core_if;
`ifdef SHA256_MIDSTATE_EN
  logic [255:0] mid_in;
  logic         mid_sel;
`endif
  logic         abort;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] digest;
  logic         busy;

  modport master (
`ifdef SHA256_MIDSTATE_EN
    output mid_in, output mid_sel,
`endif
    output abort, output blk_valid, input blk_ready, output blk_data,
    output blk_first, output blk_last, input dig_valid, output dig_ready,
    input digest, input busy
  );

  modport slave (
`ifdef SHA256_MIDSTATE_EN
    input mid_in, input mid_sel,
`endif
    input abort, input blk_valid, output blk_ready, input blk_data,
    input blk_first, input blk_last, output dig_valid, input dig_ready,
    output digest, output busy
  );
endinterface
`default_nettype wire

// File: rtl/sha256_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : sha256_stream_core
// Purpose  : Streaming SHA-256 / SHA256d engine, UNROLL rounds per clock.
//            Optional midstate seeding guarded by SHA256_MIDSTATE_EN.
// Revision : 1.0  initial release
// ============================================================================
module sha256_stream_core #(
  parameter int UNROLL = 1,
  parameter int DOUBLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  sha256_stream_core_if.slave s
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_ADD   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [2047:0] K_TAB = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [5:0] LAST_RND = 6'(64 - UNROLL);
  localparam logic [5:0] RND_STEP = 6'(UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("sha256_stream_core: UNROLL must be 1, 2 or 4");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] k_at(input logic [5:0] idx);
    return K_TAB[2047 - 32 * int'(idx) -: 32];
  endfunction

  // One compression round; the window always holds W[t..t+15] with W[t] on top.
  function automatic logic [767:0] sha_round(input logic [255:0] st,
                                             input logic [511:0] w,
                                             input logic [31:0]  k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, wn;
    {a, b, c, d, e, f, g, h} = st;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w[511:480];
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    wn = ssig1(w[63:32]) + w[223:192] + ssig0(w[479:448]) + w[511:480];
    return {t1 + t2, a, b, c, d + t1, e, f, g, w[479:0], wn};
  endfunction

  logic [1:0]   state;
  logic [5:0]   rnd;
  logic [255:0] h_q;
  logic [255:0] st_q;
  logic [511:0] w_q;
  logic         pass_q;
  logic         blk_last_q;
  logic         dig_valid_q;
  logic [255:0] digest_q;

  logic [255:0] st_nxt;
  logic [511:0] w_nxt;
  logic [255:0] h_sum;
  logic [255:0] init_cv;

  always_comb begin
    st_nxt = st_q;
    w_nxt  = w_q;
    for (int j = 0; j < UNROLL; j++) begin
      {st_nxt, w_nxt} = sha_round(st_nxt, w_nxt, k_at(rnd + 6'(j)));
    end
  end

  always_comb begin
    h_sum = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i*32 +: 32] = h_q[i*32 +: 32] + st_q[i*32 +: 32];
    end
  end

  always_comb begin
    init_cv = h_q;
    if (s.blk_first) begin
`ifdef SHA256_MIDSTATE_EN
      init_cv = s.mid_sel ? s.mid_in : IV;
`else
      init_cv = IV;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rnd         <= '0;
      h_q         <= IV;
      st_q        <= '0;
      w_q         <= '0;
      pass_q      <= 1'b0;
      blk_last_q  <= 1'b0;
      dig_valid_q <= 1'b0;
      digest_q    <= '0;
    end else if (s.abort) begin
      state       <= S_IDLE;
      dig_valid_q <= 1'b0;
      pass_q      <= 1'b0;
      h_q         <= IV;
    end else begin
      case (state)
        S_IDLE: begin
          if (s.blk_valid) begin
            w_q        <= s.blk_data;
            st_q       <= init_cv;
            h_q        <= init_cv;
            rnd        <= '0;
            blk_last_q <= s.blk_last;
            state      <= S_ROUND;
          end
        end
        S_ROUND: begin
          st_q <= st_nxt;
          w_q  <= w_nxt;
          if (rnd == LAST_RND) begin
            state <= S_ADD;
          end else begin
            rnd <= rnd + RND_STEP;
          end
        end
        S_ADD: begin
          if (!blk_last_q) begin
            h_q   <= h_sum;
            state <= S_IDLE;
          end else if (DOUBLE != 0 && !pass_q) begin
            // Second pass hashes the 32-byte digest as a single padded block.
            w_q    <= {h_sum, 32'h80000000, 192'h0, 32'h00000100};
            h_q    <= IV;
            st_q   <= IV;
            rnd    <= '0;
            pass_q <= 1'b1;
            state  <= S_ROUND;
          end else begin
            digest_q    <= h_sum;
            dig_valid_q <= 1'b1;
            pass_q      <= 1'b0;
            state       <= S_OUT;
          end
        end
        S_OUT: begin
          if (s.dig_ready) begin
            dig_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign s.blk_ready = (state == S_IDLE);
  assign s.busy      = (state != S_IDLE);
  assign s.dig_valid = dig_valid_q;
  assign s.digest    = digest_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_stream_core
// Purpose  : Directed vectors over four core configurations (UNROLL 1/4 x DOUBLE 0/1).
// Revision : 1.0  initial release
// ============================================================================
module tb_sha256_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, abort, blk_valid, blk_first, blk_last, dig_ready;
  logic [511:0] blk_data;
`ifdef SHA256_MIDSTATE_EN
  logic [255:0] mid_in;
  logic         mid_sel;
`endif
  logic [3:0]   dv, br, bz;
  logic [255:0] dg [4];
  int total = 0;
  int bad   = 0;

  for (genvar i = 0; i < 4; i++) begin : g_dut
    sha256_stream_core_if bus ();
    assign bus.abort     = abort;
    assign bus.blk_valid = blk_valid;
    assign bus.blk_data  = blk_data;
    assign bus.blk_first = blk_first;
    assign bus.blk_last  = blk_last;
    assign bus.dig_ready = dig_ready;
`ifdef SHA256_MIDSTATE_EN
    assign bus.mid_in  = mid_in;
    assign bus.mid_sel = mid_sel;
`endif
    assign dv[i] = bus.dig_valid;
    assign br[i] = bus.blk_ready;
    assign bz[i] = bus.busy;
    assign dg[i] = bus.digest;
    sha256_stream_core #(.UNROLL((i % 2 == 0) ? 1 : 4), .DOUBLE(i / 2)) u_dut (
      .clk(clk), .rst_n(rst_n), .s(bus)
    );
  end

  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TB1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
    32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
    32'h80000000, 32'h00000000};
  localparam logic [511:0] TB2 = {480'h0, 32'h000001c0};
  localparam logic [511:0] G1  = {32'h01000000, 256'h0, 32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e,
                                  32'h67768f61, 32'h7fc81bc3, 32'h888a5132, 32'h3a9fb8aa};
  localparam logic [511:0] G2  = {32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c,
                                  32'h80000000, 320'h0, 32'h00000280};
  localparam logic [255:0] ABC_S = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC_D = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] TB_S  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] GEN_D = 256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

  typedef struct packed {
    logic [1:0]    nblk;
    logic [1023:0] blks;
    logic [1:0]    fst;
    logic [1:0]    lst;
    logic [255:0]  exp_s;
    logic [255:0]  exp_d;
    logic          chk_s;
    logic          chk_d;
  } vec_t;
  vec_t vecs [4];

  function automatic int r_of(input int i);
    return (i % 2 == 0) ? 64 : 16;
  endfunction

  function automatic logic [255:0] exp_for(input int i, input logic [255:0] es, input logic [255:0] ed);
    return (i >= 2) ? ed : es;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (br != 4'hF && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (br != 4'hF) chk("ready_timeout", 256'(br), 256'hF);
  endtask

  task automatic send(input logic [511:0] d, input logic f, input logic l);
    wait_ready();
    blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0; blk_data = '1; blk_first = 1'b0; blk_last = 1'b0;
  endtask

  // Clocks after the accept edge until blk_ready is back for a non-last block.
  task automatic measure_ready(input string name);
    int m = 0;
    int got [4] = '{default: 0};
    while (br != 4'hF && m < 300) begin
      @(posedge clk); #1; m++;
      for (int i = 0; i < 4; i++) if (br[i] && got[i] == 0) got[i] = m;
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_rdy_lat%0d", name, i), 256'(got[i]), 256'(r_of(i) + 1));
  endtask

  // Latency counted with the accept edge as clock 1.
  task automatic wait_digest(input string name);
    int n = 1;
    int got [4] = '{default: 0};
    while (dv != 4'hF && n < 400) begin
      @(posedge clk); #1; n++;
      for (int i = 0; i < 4; i++) if (dv[i] && got[i] == 0) got[i] = n;
    end
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_lat%0d", name, i), 256'(got[i]),
          256'((i >= 2) ? 2 * r_of(i) + 3 : r_of(i) + 2));
  endtask

  task automatic release_digest(input string name);
    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    chk({name, "_rel"}, {248'h0, dv, br}, {248'h0, 4'h0, 4'hF});
  endtask

`ifdef SHA256_MIDSTATE_EN
  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [2047:0] KT = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression with a full 64-entry schedule, used to derive the header midstate.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] res;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + KT[2047 - 32*t -: 32] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return res;
  endfunction
`endif

  initial begin
    rst_n = 1'b0; abort = 1'b0; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    dig_ready = 1'b0; blk_data = '0;
`ifdef SHA256_MIDSTATE_EN
    mid_in = '0; mid_sel = 1'b0;
`endif
    vecs[0] = '{2'd1, {ABC, 512'h0}, 2'b01, 2'b01, ABC_S, ABC_D, 1'b1, 1'b1};
    vecs[1] = '{2'd2, {TB1, TB2},    2'b01, 2'b10, TB_S,  256'h0, 1'b1, 1'b0};
    vecs[2] = '{2'd2, {G1, G2},      2'b01, 2'b10, 256'h0, GEN_D, 1'b0, 1'b1};
    vecs[3] = '{2'd2, {TB1, ABC},    2'b11, 2'b10, ABC_S, ABC_D, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", {248'h0, dv, bz}, 256'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("rst_digest%0d", i), dg[i], 256'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 256'(br), 256'hF);

    for (int v = 0; v < 4; v++) begin
      for (int b = 0; b < int'(vecs[v].nblk); b++) begin
        send(vecs[v].blks[1023 - 512*b -: 512], vecs[v].fst[b], vecs[v].lst[b]);
        if (vecs[v].lst[b]) begin
          wait_digest($sformatf("v%0d", v));
          for (int i = 0; i < 4; i++)
            if ((i >= 2) ? vecs[v].chk_d : vecs[v].chk_s)
              chk($sformatf("v%0d_digest%0d", v, i), dg[i], exp_for(i, vecs[v].exp_s, vecs[v].exp_d));
          release_digest($sformatf("v%0d", v));
        end else begin
          measure_ready($sformatf("v%0d_b%0d", v, b));
        end
      end
    end

    // Back-pressure: digest must hold while dig_ready stays low.
    send(ABC, 1'b1, 1'b1);
    wait_digest("hold");
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_flags%0d", k), {248'h0, dv, br}, {248'h0, 4'hF, 4'h0});
      for (int i = 0; i < 4; i++) chk($sformatf("hold_dg%0d_%0d", k, i), dg[i], exp_for(i, ABC_S, ABC_D));
    end
    release_digest("hold");

    // Abort mid-ROUND after a chaining block: H must return to IV.
    send(TB1, 1'b1, 1'b0);
    measure_ready("ab_pre");
    send(ABC, 1'b0, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_flags", {248'h0, dv, br, bz}, {244'h0, 4'h0, 4'hF, 4'h0});
    chk("abort_dg0", dg[0], ABC_S);
    chk("abort_dg2", dg[2], ABC_D);
    chk("abort_dg3", dg[3], ABC_D);
    send(ABC, 1'b0, 1'b1);
    wait_digest("post_abort");
    for (int i = 0; i < 4; i++) chk($sformatf("post_abort_dg%0d", i), dg[i], exp_for(i, ABC_S, ABC_D));
    release_digest("post_abort");

    // Abort on the accept edge drops the block.
    wait_ready();
    blk_data = ABC; blk_first = 1'b1; blk_last = 1'b1; blk_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    blk_valid = 1'b0; abort = 1'b0;
    chk("abort_accept", {248'h0, br, bz}, {248'h0, 4'hF, 4'h0});
    repeat (140) @(posedge clk);
    #1;
    chk("abort_accept_nodig", 256'(dv), 256'h0);

`ifdef SHA256_MIDSTATE_EN
    mid_in = compress(IV, G1);
    mid_sel = 1'b1;
    send(G2, 1'b1, 1'b1);
    mid_sel = 1'b0;
    wait_digest("mid");
    chk("mid_dg2", dg[2], GEN_D);
    chk("mid_dg3", dg[3], GEN_D);
    release_digest("mid");
`endif

    // Asynchronous reset in the middle of ROUND.
    send(ABC, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_flags", {248'h0, dv, bz}, 256'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("mid_rst_dg%0d", i), dg[i], 256'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready", 256'(br), 256'hF);
    send(ABC, 1'b1, 1'b1);
    wait_digest("recover");
    for (int i = 0; i < 4; i++) chk($sformatf("recover_dg%0d", i), dg[i], exp_for(i, ABC_S, ABC_D));
    release_digest("recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
